serial_add_sub: RTL
===================

Name: serial_add_sub

Overview:
Bit-serial add/subtract engine with the same operation selection as the team's combinational add/sub block: SEL=1 adds, SEL=0 subtracts (A minus B). It latches parallel operands and uses a single full-adder/full-subtractor slice over WIDTH cycles, LSB first. The result comes back as a parallel word with carry or borrow. It serves area-constrained datapaths where a WIDTH-bit ripple adder/subtractor is too large, with a START/BUSY/DONE handshake to the controlling sequencer.

Parameters:
WIDTH, 8, operand and result width in bits (min 2)

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
START  input  1  request; sampled only when not BUSY
SEL  input  1  operation, captured with START: 1 = A+B, 0 = A-B
A  input  WIDTH  first operand (minuend for subtract), captured with START
B  input  WIDTH  second operand (subtrahend for subtract), captured with START
BUSY  output  1  high while bits are being processed
DONE  output  1  one-cycle pulse when RESULT/CARRY become valid
RESULT  output  WIDTH  sum or difference, modulo 2^WIDTH
CARRY  output  1  carry-out (add) or borrow-out (subtract)

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RST_N, and is applied immediately regardless of CLK.
- Reset values: state=IDLE, BUSY=0, DONE=0, RESULT=0, CARRY=0, bit counter=0, operand and carry registers=0.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - START=1 at edge t0: latch A, B and SEL; clear the carry/borrow register to 0; counter=0; go to RUN.
  - START=0: remain in IDLE.
- RUN: one bit per edge.
  - Slice inputs are a=A_reg[0], b=B_reg[0], c=carry register.
  - Add: s = a^b^c; cout = (a&b)|(c&(a^b)).
  - Subtract: d = a^b^c; bout = (~a&b)|(~(a^b)&c).
  - Each edge: shift A_reg and B_reg right by 1. Shift the result register right with the slice output entering at the MSB. Update the carry register. Increment the counter.
  - On the edge processing bit WIDTH-1, go to FIN.
- FIN (exactly one cycle):
  - DONE=1, BUSY=0.
  - RESULT equals the completed result register; CARRY equals the final carry/borrow.
  - Next edge goes to IDLE. If START=1 at that edge, the new operation is accepted directly into RUN (back-to-back; the FIN cycle counts as not busy).
- Latency:
  - START accepted at edge t0; BUSY=1 after edges t0 through t0+WIDTH-1.
  - DONE=1 during the cycle after edge t0+WIDTH.
  - For WIDTH=8, DONE is high 9 edges after the accepting edge, counting that edge as 1.
- RESULT and CARRY are registered and hold their last completed value until the next operation completes. They do not change during RUN; the working shift register is separate from the RESULT output register.
- START while in RUN is ignored: no queuing, no restart.
- Changes on A, B or SEL after acceptance have no effect on the operation in flight.
- RST_N asserted mid-RUN aborts the operation; all outputs return to their reset values. Operation resumes from IDLE after deassertion.
- Arithmetic:
  - Add: {CARRY,RESULT} = A+B, unsigned.
  - Subtract: RESULT = (A-B) mod 2^WIDTH; CARRY=1 iff A<B unsigned.
- Counter width: clog2(WIDTH) bits. It wraps to 0 on entering FIN.

Decomposition:
- Shared package/include: state encodings IDLE=2'd0, RUN=2'd1, FIN=2'd2; SEL encodings OP_ADD=1'b1, OP_SUB=1'b0.
- One sub-module is natural: full_add_sub, a combinational 1-bit full adder/subtractor with a mode input. It has inputs a, b, cin, mode and outputs s, cout (carry or borrow), built from the existing half-adder and half-subtractor blocks. It is instantiated once; the FSM, counter and shift registers stay in serial_add_sub.

Test Plan:
- Add with carry-out (WIDTH=8): SEL=1, A=200, B=100, one-cycle START -> BUSY for 8 cycles; DONE pulse 9 edges after the accepting edge; RESULT=44, CARRY=1.
- Subtract with borrow: SEL=0, A=5, B=9 -> RESULT=252, CARRY=1. Then SEL=0, A=9, B=5 -> RESULT=4, CARRY=0.
- Boundary values:
  - A=255, B=1, add -> RESULT=0, CARRY=1.
  - A=0, B=0, subtract -> RESULT=0, CARRY=0.
  - A=0, B=255, subtract -> RESULT=1, CARRY=1.
- START during RUN and operand changes:
  - START pulsed and A/B/SEL changed mid-operation -> original result unchanged.
  - Only one DONE pulse.
  - RESULT/CARRY hold their previous values until DONE.
- Back-to-back: START held high through FIN -> the second operation is accepted in the FIN cycle and its DONE arrives exactly WIDTH+1 edges after the first DONE.
- Reset mid-RUN: RST_N low asynchronously at bit 4 -> BUSY, DONE, RESULT and CARRY go to 0 immediately, before the next edge. After release, a new A=3, B=4 add gives RESULT=7, CARRY=0.

Source files
------------

// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial add/subtract engine.
//   state_e   : FSM encoding (IDLE/RUN/FIN), also driven out on dbg_state
//   OP_ADD/OP_SUB : SEL encodings, identical to the combinational add/sub block
//   half_add / half_sub : the half-adder and half-subtractor cells that the
//                         1-bit full add/sub slice is composed from
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  // s: sum/difference bit, c: carry/borrow bit
  typedef struct packed {
    logic s;
    logic c;
  } half_t;

  function automatic half_t half_add(input logic a, input logic b);
    half_t r;
    r.s = a ^ b;
    r.c = a & b;
    return r;
  endfunction

  function automatic half_t half_sub(input logic a, input logic b);
    half_t r;
    r.s = a ^ b;
    r.c = ~a & b;
    return r;
  endfunction

endpackage

// File: rtl/serial_add_sub_full_add_sub.sv
// Combinational 1-bit full adder / full subtractor.
//   a, b  : operand bits (a is the minuend when subtracting)
//   cin   : incoming carry (add) or borrow (subtract)
//   mode  : OP_ADD = a+b+cin, OP_SUB = a-b-cin
//   s     : sum or difference bit
//   cout  : carry-out or borrow-out
// Built as two cascaded half cells; the sum/difference bit is the same XOR
// chain in both modes, only the carry/borrow combine differs.
module full_add_sub
  import serial_add_sub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic mode,
  output logic s,
  output logic cout
);

  half_t ha1, ha2, hs1, hs2;

  always_comb begin
    ha1  = half_add(a, b);
    ha2  = half_add(ha1.s, cin);
    hs1  = half_sub(a, b);
    hs2  = half_sub(hs1.s, cin);
    s    = ha2.s;
    cout = 1'b0;
    if (mode == OP_ADD) cout = ha1.c | ha2.c;
    else                cout = hs1.c | hs2.c;
  end

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract engine: latches A/B/SEL on START, processes one bit
// per clock LSB first through a single full add/sub slice, then presents the
// parallel RESULT and CARRY (carry-out for add, borrow-out for subtract).
//   CLK, RST_N : clock, asynchronous active-low reset
//   START      : request, accepted whenever not BUSY (IDLE or FIN)
//   SEL        : 1 = A+B, 0 = A-B, captured with START
//   A, B       : operands, captured with START
//   BUSY       : high while bits are being processed
//   DONE       : one-cycle pulse, RESULT/CARRY valid from this cycle on
//   RESULT     : sum/difference mod 2^WIDTH, held until the next completion
//   CARRY      : carry-out / borrow-out, held with RESULT
//   dbg_state  : current FSM state for observation
//
// Handshake: START is sampled on every rising edge where BUSY=0; a sample of
// START=1 is an acceptance (no ready signal, BUSY low is the ready). The FIN
// cycle counts as not busy, so a START held high there is accepted directly
// into RUN. START while BUSY is dropped, never queued.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             SEL,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             CARRY,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, res_q;
  logic             sel_q, cy_q, carry_q;
  logic             slice_s, slice_c;
  logic             accept, last_bit;

  assign accept   = START && (state_q != RUN);
  assign last_bit = (state_q == RUN) && (cnt_q == LAST);

  full_add_sub u_slice (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (cy_q),
    .mode (sel_q),
    .s    (slice_s),
    .cout (slice_c)
  );

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (START) state_d = RUN;
      RUN:     if (last_bit) state_d = FIN;
      FIN:     state_d = START ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand shifters, working accumulator, counter and the
  // separate output register that only updates when the last bit lands.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      sel_q   <= 1'b0;
      cy_q    <= 1'b0;
      carry_q <= 1'b0;
    end else if (accept) begin
      a_q   <= A;
      b_q   <= B;
      sel_q <= SEL;
      acc_q <= '0;
      cy_q  <= 1'b0;
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      a_q   <= a_q >> 1;
      b_q   <= b_q >> 1;
      acc_q <= {slice_s, acc_q[WIDTH-1:1]};
      cy_q  <= slice_c;
      // explicit wrap so non-power-of-two widths also return to 0
      cnt_q <= last_bit ? '0 : cnt_q + 1'b1;
      if (last_bit) begin
        res_q   <= {slice_s, acc_q[WIDTH-1:1]};
        carry_q <= slice_c;
      end
    end
  end

  // Outputs
  always_comb begin
    BUSY      = (state_q == RUN);
    DONE      = (state_q == FIN);
    RESULT    = res_q;
    CARRY     = carry_q;
    dbg_state = state_q;
  end

endmodule
